// File: rtl/complement_to_1_encoder.sv
// complement_to_1_encoder
// Converts two two's-complement operands to one's-complement form bit-serially
// (LSB first, ripple borrow, one bit per clock) and packs them with the op code
// into {A_1c, B_1c, op}. The operand -2^(WIDTH-1) saturates and flags ovf.
module complement_to_1_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 complement2_sel,
  input  logic                 wr_enable,
  input  logic [WIDTH-1:0]     first_nr,
  input  logic [WIDTH-1:0]     second_nr,
  input  logic [3:0]           operation,
  output logic [2*WIDTH+3:0]   nr_coded,
  output logic                 busy,
  output logic [1:0]           ovf,
  output logic                 complement2_finish
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               bor_a_q, bor_a_d;
  logic               bor_b_q, bor_b_d;
  logic               min_a_q, min_a_d;
  logic               min_b_q, min_b_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH+3:0] nr_coded_q, nr_coded_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               finish_q, finish_d;

  logic               accept;
  logic               min_a_in, min_b_in;
  logic               d_a, d_b;
  logic [WIDTH-1:0]   res_a, res_b;

  // Next-state logic: accept/capture, serial borrow ripple, result commit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    bor_a_d    = bor_a_q;
    bor_b_d    = bor_b_q;
    min_a_d    = min_a_q;
    min_b_d    = min_b_q;
    op_d       = op_q;
    nr_coded_d = nr_coded_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    finish_d   = finish_q;

    accept   = complement2_sel & wr_enable & (state_q != ST_CONV);
    min_a_in = (first_nr == MIN_VAL);
    min_b_in = (second_nr == MIN_VAL);

    // Operands shift right; each converted bit enters at the MSB, so after
    // WIDTH shifts the register holds the converted value in place.
    d_a   = sh_a_q[0] ^ bor_a_q;
    d_b   = sh_b_q[0] ^ bor_b_q;
    res_a = min_a_q ? MIN_VAL : sh_a_q;
    res_b = min_b_q ? MIN_VAL : sh_b_q;

    if (accept) begin
      state_d  = ST_CONV;
      cnt_d    = '0;
      sh_a_d   = first_nr;
      sh_b_d   = second_nr;
      bor_a_d  = first_nr[WIDTH-1] & ~min_a_in;
      bor_b_d  = second_nr[WIDTH-1] & ~min_b_in;
      min_a_d  = min_a_in;
      min_b_d  = min_b_in;
      op_d     = operation;
      finish_d = 1'b0;
      busy_d   = 1'b1;
    end else if (state_q == ST_CONV) begin
      // Bits are processed while cnt < WIDTH; the extra edge at cnt == WIDTH
      // commits the result, giving finish on edge WIDTH+1 after accept.
      if (cnt_q == CW'(WIDTH)) begin
        state_d    = ST_DONE;
        nr_coded_d = {res_a, res_b, op_q};
        ovf_d      = {min_a_q, min_b_q};
        finish_d   = 1'b1;
        busy_d     = 1'b0;
      end else begin
        sh_a_d  = {d_a, sh_a_q[WIDTH-1:1]};
        sh_b_d  = {d_b, sh_b_q[WIDTH-1:1]};
        bor_a_d = ~sh_a_q[0] & bor_a_q;
        bor_b_d = ~sh_b_q[0] & bor_b_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      bor_a_q    <= 1'b0;
      bor_b_q    <= 1'b0;
      min_a_q    <= 1'b0;
      min_b_q    <= 1'b0;
      op_q       <= '0;
      nr_coded_q <= '0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      bor_a_q    <= bor_a_d;
      bor_b_q    <= bor_b_d;
      min_a_q    <= min_a_d;
      min_b_q    <= min_b_d;
      op_q       <= op_d;
      nr_coded_q <= nr_coded_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  assign nr_coded           = nr_coded_q;
  assign ovf                = ovf_q;
  assign busy               = busy_q;
  assign complement2_finish = finish_q;

endmodule

// File: tb/tb_complement_to_1_encoder.sv
// Testbench for complement_to_1_encoder: table-driven vectors, random vectors
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_complement_to_1_encoder;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 complement2_sel;
  logic                 wr_enable;
  logic [WIDTH-1:0]     first_nr;
  logic [WIDTH-1:0]     second_nr;
  logic [3:0]           operation;
  logic [2*WIDTH+3:0]   nr_coded;
  logic                 busy;
  logic [1:0]           ovf;
  logic                 complement2_finish;

  complement_to_1_encoder #(.WIDTH(WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .complement2_sel    (complement2_sel),
    .wr_enable          (wr_enable),
    .first_nr           (first_nr),
    .second_nr          (second_nr),
    .operation          (operation),
    .nr_coded           (nr_coded),
    .busy               (busy),
    .ovf                (ovf),
    .complement2_finish (complement2_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [19:0] exp_nr;
    logic [1:0]  exp_ovf;
  } vec_t;

  typedef struct {
    logic [19:0] nr;
    logic [1:0]  ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] to_1c(input logic [7:0] x);
    if (x == 8'h80)  return 8'h80;
    else if (x[7])   return x - 8'd1;
    else             return x;
  endfunction

  // Drive one accept cycle; returns right after the accepting edge (+1).
  task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clk);
    first_nr = a; second_nr = b; operation = op;
    complement2_sel = 1'b1; wr_enable = 1'b1;
    @(posedge clk); #1;
    complement2_sel = 1'b0; wr_enable = 1'b0;
  endtask

  // Bounded wait for finish; returns edges counted after the accepting edge.
  task automatic wait_finish(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (complement2_finish) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, "_nr"}, 32'(nr_coded), 32'(e.nr));
    check({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [19:0] enr, input logic [1:0] eovf);
    exp_t e;
    int lat;
    e.nr = enr; e.ovf = eovf;
    sb.push_back(e);
    do_accept(a, b, op);
    check({name, "_finish_low_at_accept"}, 32'(complement2_finish), 32'd0);
    check({name, "_busy_at_accept"}, 32'(busy), 32'd1);
    wait_finish(lat);
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    pop_compare(name);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    logic [19:0] hold_nr;
    logic [7:0]  ra, rb;
    logic [3:0]  rop;
    int          saw;

    vecs[0] = '{8'h05, 8'hFB, 4'h3, 20'h05FA3, 2'b00};
    vecs[1] = '{8'hFF, 8'h81, 4'hA, 20'hFE80A, 2'b00};
    vecs[2] = '{8'h80, 8'h00, 4'h1, 20'h80001, 2'b10};
    vecs[3] = '{8'h7F, 8'h7F, 4'hF, 20'h7F7FF, 2'b00};
    vecs[4] = '{8'h80, 8'h80, 4'h5, 20'h80805, 2'b11};
    vecs[5] = '{8'hFE, 8'h00, 4'h7, 20'hFD007, 2'b00};
    vecs[6] = '{8'h00, 8'h80, 4'h2, 20'h00802, 2'b01};
    vecs[7] = '{8'hC0, 8'h3A, 4'h9, 20'hBF3A9, 2'b00};
    vecs[8] = '{8'h00, 8'h00, 4'h0, 20'h00000, 2'b00};

    rst = 1'b1; complement2_sel = 1'b0; wr_enable = 1'b0;
    first_nr = '0; second_nr = '0; operation = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_nr", 32'(nr_coded), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_finish", 32'(complement2_finish), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].exp_nr, vecs[i].exp_ovf);

    // Random vectors against the arithmetic reference
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom);
      if (i == 0) ra = 8'h80;
      if (i == 1) rb = 8'hFF;
      run_vec($sformatf("rnd%0d", i), ra, rb, rop, {to_1c(ra), to_1c(rb), rop},
              {(ra == 8'h80), (rb == 8'h80)});
    end

    // Request during CONV is ignored
    begin
      exp_t e;
      e.nr = 20'h05FA3; e.ovf = 2'b00;
      sb.push_back(e);
      do_accept(8'h05, 8'hFB, 4'h3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      first_nr = 8'h80; second_nr = 8'h80; operation = 4'hC;
      complement2_sel = 1'b1; wr_enable = 1'b1;
      @(posedge clk); #1;
      complement2_sel = 1'b0; wr_enable = 1'b0;
      check("ignore_busy_mid", 32'(busy), 32'd1);
      lat = -1;
      for (int k = 4; k <= 30; k++) begin
        @(posedge clk); #1;
        if (complement2_finish) begin lat = k; break; end
      end
      check("ignore_latency", 32'(lat), 32'(LAT));
      pop_compare("ignore");
      saw = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (busy || !complement2_finish || nr_coded != 20'h05FA3) saw = 1;
      end
      check("ignore_single_finish", 32'(saw), 32'd0);
    end

    // Reset mid-CONV aborts without a finish
    do_accept(8'hFF, 8'h81, 4'hA);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_nr", 32'(nr_coded), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_finish", 32'(complement2_finish), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst = 1'b0;
    saw = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (complement2_finish || busy) saw = 1;
    end
    check("abort_no_finish", 32'(saw), 32'd0);
    run_vec("after_abort", 8'h01, 8'hFE, 4'h0, 20'h01FD0, 2'b00);

    // sel without wr_enable is ignored; then re-accept from DONE
    @(negedge clk);
    first_nr = 8'h80; second_nr = 8'h7F; operation = 4'h6;
    complement2_sel = 1'b1; wr_enable = 1'b0;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy || !complement2_finish || nr_coded != 20'h01FD0 || ovf != 2'b00) saw = 1;
    end
    check("no_we_stable", 32'(saw), 32'd0);
    complement2_sel = 1'b0;
    hold_nr = nr_coded;
    begin
      exp_t e;
      e.nr = 20'h807F6; e.ovf = 2'b10;
      sb.push_back(e);
      do_accept(8'h80, 8'h7F, 4'h6);
      check("redo_finish_drop", 32'(complement2_finish), 32'd0);
      check("redo_old_nr_held", 32'(nr_coded), 32'(hold_nr));
      wait_finish(lat);
      check("redo_latency", 32'(lat), 32'(LAT));
      pop_compare("redo");
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1);
  end

endmodule
